// File: rtl/carregador_programa_if.sv
// Byte-stream and RAM-programming signal bundle between host, loader and SAP-1 RAM/MAR.
interface carregador_programa_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              iniciar;
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              run_prog;
    logic              leitura_escrita;
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              erro;

    modport master (
        input  iniciar, byte_in, byte_valid,
        output byte_ready, run_prog, leitura_escrita, ce, addr, data_out, done, erro
    );

    modport slave (
        output iniciar, byte_in, byte_valid,
        input  byte_ready, run_prog, leitura_escrita, ce, addr, data_out, done, erro
    );
endinterface

// File: rtl/carregador_programa.sv
// SAP-1 program loader: streams N_WORDS bytes into RAM with a setup/write/hold strobe
// sequence, verifies an optional mod-256 checksum, then releases the CPU to execute mode.
module carregador_programa #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned N_WORDS     = 16,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input logic                   CLK,
    input logic                   CLR,
    carregador_programa_if.master bus
);
    localparam int unsigned LAST = N_WORDS - 1;

    typedef enum logic [2:0] {
        IDLE, RECV, SETUP, WRITE, HOLD, CHK, DONE, ERRO
    } state_t;

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] cnt_q, cnt_nxt;
    logic [DATA_W-1:0] acc_q, acc_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              byte_ready_q, run_prog_q, le_q, ce_q, done_q, erro_q;
    logic              xfer_c;

    assign xfer_c = bus.byte_valid && byte_ready_q;

    // Next state and datapath updates
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        acc_nxt   = acc_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state_q)
            IDLE, DONE, ERRO: begin
                if (bus.iniciar) begin
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (xfer_c) begin
                    data_nxt  = bus.byte_in;
                    addr_nxt  = cnt_q;
                    acc_nxt   = acc_q + bus.byte_in;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = WRITE;
            WRITE: state_nxt = HOLD;
            HOLD: begin
                if (cnt_q != ADDR_W'(LAST)) begin
                    cnt_nxt   = cnt_q + ADDR_W'(1);
                    state_nxt = RECV;
                end else if (CHECKSUM_EN) begin
                    state_nxt = CHK;
                end else begin
                    state_nxt = DONE;
                end
            end
            CHK: begin
                if (xfer_c) begin
                    state_nxt = (bus.byte_in == acc_q) ? DONE : ERRO;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and outputs, all registered from the next state
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            byte_ready_q <= 1'b0;
            run_prog_q   <= 1'b0;
            le_q         <= 1'b1;
            ce_q         <= 1'b0;
            done_q       <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            acc_q        <= acc_nxt;
            addr_q       <= addr_nxt;
            data_q       <= data_nxt;
            byte_ready_q <= (state_nxt == RECV) || (state_nxt == CHK);
            run_prog_q   <= (state_nxt == DONE);
            le_q         <= (state_nxt != WRITE);
            ce_q         <= (state_nxt == SETUP) || (state_nxt == WRITE) || (state_nxt == HOLD);
            done_q       <= (state_nxt == DONE);
            erro_q       <= (state_nxt == ERRO);
        end
    end

    assign bus.byte_ready      = byte_ready_q;
    assign bus.run_prog        = run_prog_q;
    assign bus.leitura_escrita = le_q;
    assign bus.ce              = ce_q;
    assign bus.addr            = addr_q;
    assign bus.data_out        = data_q;
    assign bus.done            = done_q;
    assign bus.erro            = erro_q;
endmodule
